// File: rtl/prog_loader_pkg.sv
// Shared constants for the boot-time program loader: FSM encoding and
// instruction-memory address limits.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        LOAD = 3'd2,
        CHK  = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } loadState;

    // Address 0xFF is the processor halt vector; a maximal image ends at 0xFE.
    localparam logic [7:0] HALT_ADDR = 8'hFF;
    localparam logic [7:0] LEN_MAX   = 8'd255;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input handshake plus instruction-memory write port of the loader.
interface prog_loader_if #(
    parameter int IM_ADDR_W_m1 = 7,
    parameter int IM_DATA_W_m1 = 7
);
    logic                    in_valid;
    logic [7:0]              in_data;
    logic                    in_ready;
    logic                    im_we;
    logic [IM_ADDR_W_m1:0]   im_addr;
    logic [IM_DATA_W_m1:0]   im_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, im_we, im_addr, im_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/prog_loader_byte_csum.sv
// 8-bit XOR accumulator; clear has priority over accumulate.
module byte_csum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] acc
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      acc <= 8'h00;
        else if (clr) acc <= 8'h00;
        else if (en)  acc <= acc ^ din;
    end
endmodule

// File: rtl/prog_loader.sv
// Loads a framed (length, bytes, XOR checksum) image into instruction memory
// and keeps the processor held until a checksum-valid image is in place.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int IM_ADDR_W_m1 = 7,
    parameter int IM_DATA_W_m1 = 7
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    prog_loader_if.slave   bus,
    output logic           cpu_hold,
    output logic           done,
    output logic           err,
    output logic [7:0]     count
);
    localparam int ADDR_W = IM_ADDR_W_m1 + 1;
    localparam int DATA_W = IM_DATA_W_m1 + 1;

    loadState            state, nextState;
    logic [7:0]          len;
    logic [7:0]          csum;
    logic                inReady;
    logic                lenXfer, loadXfer, chkXfer, restart;
    logic                csumOk;
    logic                imWe;
    logic [ADDR_W-1:0]   imAddr;
    logic [DATA_W-1:0]   imWdata;

    assign csumOk       = (bus.in_data == csum);
    assign bus.in_ready = inReady;
    assign bus.im_we    = imWe;
    assign bus.im_addr  = imAddr;
    assign bus.im_wdata = imWdata;

    byte_csum uCsum (
        .clk (clk),
        .rst (rst),
        .clr (lenXfer),
        .en  (loadXfer),
        .din (bus.in_data),
        .acc (csum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    // start is only honoured in states where in_ready is low, so it can never
    // collide with a byte transfer.
    always_comb begin
        nextState = state;
        inReady   = 1'b0;
        lenXfer   = 1'b0;
        loadXfer  = 1'b0;
        chkXfer   = 1'b0;
        restart   = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    restart   = 1'b1;
                    nextState = LEN;
                end
            end
            LEN: begin
                inReady = 1'b1;
                if (bus.in_valid) begin
                    lenXfer   = 1'b1;
                    nextState = (bus.in_data == 8'd0) ? CHK : LOAD;
                end
            end
            LOAD: begin
                inReady = 1'b1;
                if (bus.in_valid) begin
                    loadXfer = 1'b1;
                    if ((count + 8'd1) == len) nextState = CHK;
                end
            end
            CHK: begin
                inReady = 1'b1;
                if (bus.in_valid) begin
                    chkXfer   = 1'b1;
                    nextState = csumOk ? DONE : ERR;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len      <= 8'd0;
            count    <= 8'd0;
            imWe     <= 1'b0;
            imAddr   <= '0;
            imWdata  <= '0;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            imWe <= 1'b0;
            if (restart) begin
                count    <= 8'd0;
                cpu_hold <= 1'b1;
                done     <= 1'b0;
                err      <= 1'b0;
            end
            if (lenXfer) begin
                len   <= bus.in_data;
                count <= 8'd0;
            end
            // Write register: address/data hold their last value across stalls.
            if (loadXfer) begin
                imWe    <= 1'b1;
                imAddr  <= ADDR_W'(count);
                imWdata <= DATA_W'(bus.in_data);
                count   <= count + 8'd1;
            end
            if (chkXfer) begin
                done     <= csumOk;
                err      <= ~csumOk;
                cpu_hold <= ~csumOk;
            end
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: framed image loads, checksum failure,
// stalls, empty image, mid-load reset and a maximal 255-byte image.
module tb_prog_loader;
    import prog_loader_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       cpu_hold, done, err;
    logic [7:0] count;
    int         total = 0;
    int         bad = 0;
    int         weCount = 0;
    int         haltWrites = 0;
    int         weSnap;
    logic [7:0] lastAddr = 8'h00;

    prog_loader_if #(.IM_ADDR_W_m1(7), .IM_DATA_W_m1(7)) bus ();

    prog_loader #(.IM_ADDR_W_m1(7), .IM_DATA_W_m1(7)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err),
        .count    (count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.im_we === 1'b1) begin
            weCount++;
            lastAddr = bus.im_addr;
            if (bus.im_addr === HALT_ADDR) haltWrites++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chkWrite(input string tag, input logic [7:0] addr, input logic [7:0] data);
        chk({tag, "_we"}, bus.im_we, 1'b1);
        chk({tag, "_addr"}, bus.im_addr, addr);
        chk({tag, "_data"}, bus.im_wdata, data);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        #1 rst = 1'b1;
        #1;
        chk("rst_we", bus.im_we, 1'b0);
        chk("rst_addr", bus.im_addr, 8'h00);
        chk("rst_wdata", bus.im_wdata, 8'h00);
        chk("rst_count", count, 8'h00);
        chk("rst_hold", cpu_hold, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_ready", bus.in_ready, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        chk("idle_ready", bus.in_ready, 1'b0);

        // Good 3-byte image
        pulseStart();
        chk("len_ready", bus.in_ready, 1'b1);
        sendByte(8'h03);
        chk("t1_len_we", bus.im_we, 1'b0);
        sendByte(8'hA1);
        chkWrite("t1_w0", 8'h00, 8'hA1);
        sendByte(8'hB2);
        chkWrite("t1_w1", 8'h01, 8'hB2);
        sendByte(8'hC3);
        chkWrite("t1_w2", 8'h02, 8'hC3);
        chk("t1_count3", count, 8'd3);
        sendByte(8'hD0);
        chk("t1_done", done, 1'b1);
        chk("t1_hold", cpu_hold, 1'b0);
        chk("t1_err", err, 1'b0);
        chk("t1_count", count, 8'd3);
        chk("t1_we_off", bus.im_we, 1'b0);
        chk("t1_ready", bus.in_ready, 1'b0);

        // Bad checksum
        pulseStart();
        chk("t2_restart_done", done, 1'b0);
        chk("t2_restart_hold", cpu_hold, 1'b1);
        chk("t2_restart_count", count, 8'd0);
        sendByte(8'h03);
        sendByte(8'hA1);
        sendByte(8'hB2);
        sendByte(8'hC3);
        sendByte(8'hFF);
        chk("t2_err", err, 1'b1);
        chk("t2_done", done, 1'b0);
        chk("t2_hold", cpu_hold, 1'b1);
        chk("t2_count", count, 8'd3);

        // Stall in the middle of the program, with a stray start that must be ignored
        pulseStart();
        chk("t3_restart_err", err, 1'b0);
        sendByte(8'h02);
        sendByte(8'h11);
        chkWrite("t3_w0", 8'h00, 8'h11);
        for (int i = 0; i < 3; i++) begin
            start = (i == 1);
            tick();
            chk("t3_gap_we", bus.im_we, 1'b0);
            chk("t3_gap_addr", bus.im_addr, 8'h00);
            chk("t3_gap_data", bus.im_wdata, 8'h11);
        end
        start = 1'b0;
        sendByte(8'h22);
        chkWrite("t3_w1", 8'h01, 8'h22);
        sendByte(8'h33);
        chk("t3_done", done, 1'b1);
        chk("t3_count", count, 8'd2);

        // Empty image
        pulseStart();
        weSnap = weCount;
        sendByte(8'h00);
        chk("t4_len_we", bus.im_we, 1'b0);
        sendByte(8'h00);
        tick();
        chk("t4_no_we", weCount, weSnap);
        chk("t4_done", done, 1'b1);
        chk("t4_count", count, 8'd0);
        chk("t4_hold", cpu_hold, 1'b0);

        // Reset after two of four program bytes
        pulseStart();
        sendByte(8'h04);
        sendByte(8'h01);
        sendByte(8'h02);
        chkWrite("t5_w1", 8'h01, 8'h02);
        rst = 1'b1;
        #1;
        chk("t5_rst_we", bus.im_we, 1'b0);
        chk("t5_rst_addr", bus.im_addr, 8'h00);
        chk("t5_rst_wdata", bus.im_wdata, 8'h00);
        chk("t5_rst_count", count, 8'd0);
        chk("t5_rst_hold", cpu_hold, 1'b1);
        chk("t5_rst_done", done, 1'b0);
        chk("t5_rst_ready", bus.in_ready, 1'b0);
        weSnap = weCount;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h03;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        bus.in_valid = 1'b0;
        chk("t5_no_we", weCount, weSnap);
        chk("t5_idle_hold", cpu_hold, 1'b1);
        pulseStart();
        sendByte(8'h04);
        sendByte(8'h01);
        sendByte(8'h02);
        sendByte(8'h03);
        sendByte(8'h04);
        chkWrite("t5_w3", 8'h03, 8'h04);
        sendByte(8'h04);
        chk("t5_done", done, 1'b1);
        chk("t5_count", count, 8'd4);

        // Maximal 255-byte image 00..FE, XOR of all = FF
        pulseStart();
        sendByte(8'hFF);
        for (int i = 0; i < 255; i++) begin
            sendByte(8'(i));
            chkWrite("t6_w", 8'(i), 8'(i));
        end
        sendByte(8'hFF);
        tick();
        chk("t6_last_addr", lastAddr, 8'hFE);
        chk("t6_no_halt_write", haltWrites, 0);
        chk("t6_done", done, 1'b1);
        chk("t6_err", err, 1'b0);
        chk("t6_count", count, 8'hFF);
        chk("t6_hold", cpu_hold, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
